uart_sample_deframer: RTL and testbench

UART_SAMPLE_DEFRAMER -- requirements
Module: uart_sample_deframer

---
 rtl/uart_sample_deframer.sv | 125 ++++++++++++
 tb/tb_uart_sample_deframer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sample_deframer.sv
// Packet deframer: SYNC, LEN, LEN x 16-bit little-endian samples, XOR checksum.
// Emits samples as they complete and a status pulse at packet end or abort.
module uart_sample_deframer #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 40000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VLD,
  input  logic        RX_FERR,
  output logic [15:0] SAMPLE,
  output logic        SAMPLE_VLD,
  output logic [4:0]  SAMPLE_IDX,
  output logic        PKT_DONE,
  output logic [2:0]  ERR_CODE,
  output logic [15:0] PKT_CNT,
  output logic [7:0]  ERR_CNT
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LEN, LO, HI, CHK} state_t;

  state_t          state, state_n;
  logic [7:0]      len_r, lo_r, chk_r;
  logic [4:0]      scnt;
  logic [TW-1:0]   tmo;
  logic            byte_ok, tmo_hit, len_ok, last_smp;
  logic            emit, done_n;
  logic [2:0]      err_n;

  // A frame error in the same cycle as RX_VLD discards the byte.
  assign byte_ok  = RX_VLD & ~RX_FERR;
  assign tmo_hit  = (state != IDLE) && !RX_VLD && !RX_FERR &&
                    (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign len_ok   = (RX_DATA != 8'd0) && (RX_DATA <= 8'(MAX_LEN));
  assign last_smp = ({3'b000, scnt} + 8'd1) == len_r;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (byte_ok && RX_DATA == SYNC_BYTE) state_n = LEN;
      LEN:  if (byte_ok) state_n = len_ok ? LO : IDLE;
      LO:   if (byte_ok) state_n = HI;
      HI:   if (byte_ok) state_n = last_smp ? CHK : LO;
      CHK:  if (byte_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && (RX_FERR || tmo_hit)) state_n = IDLE;
  end

  always_comb begin
    emit   = (state == HI) && byte_ok;
    done_n = 1'b0;
    err_n  = '0;
    if (state != IDLE && RX_FERR) begin
      done_n = 1'b1;
      err_n  = 3'd3;
    end else if (tmo_hit) begin
      done_n = 1'b1;
      err_n  = 3'd4;
    end else if (byte_ok && state == LEN && !len_ok) begin
      done_n = 1'b1;
      err_n  = 3'd2;
    end else if (byte_ok && state == CHK) begin
      done_n = 1'b1;
      err_n  = (RX_DATA == chk_r) ? 3'd0 : 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SAMPLE     <= '0;
      SAMPLE_VLD <= 1'b0;
      SAMPLE_IDX <= '0;
      PKT_DONE   <= 1'b0;
      ERR_CODE   <= '0;
      PKT_CNT    <= '0;
      ERR_CNT    <= '0;
      len_r      <= '0;
      lo_r       <= '0;
      chk_r      <= '0;
      scnt       <= '0;
      tmo        <= '0;
    end else begin
      SAMPLE_VLD <= emit;
      PKT_DONE   <= done_n;
      if (emit) begin
        SAMPLE     <= {RX_DATA, lo_r};
        SAMPLE_IDX <= scnt;
        scnt       <= scnt + 5'd1;
      end
      if (done_n) begin
        ERR_CODE <= err_n;
        if (err_n == 3'd0)          PKT_CNT <= PKT_CNT + 16'd1;
        else if (ERR_CNT != 8'hFF)  ERR_CNT <= ERR_CNT + 8'd1;
      end
      if (byte_ok) begin
        unique case (state)
          IDLE: scnt <= '0;
          LEN: begin
            len_r <= RX_DATA;
            chk_r <= RX_DATA;
          end
          LO: begin
            lo_r  <= RX_DATA;
            chk_r <= chk_r ^ RX_DATA;
          end
          HI:      chk_r <= chk_r ^ RX_DATA;
          default: ;
        endcase
      end
      if (state == IDLE || state_n == IDLE || byte_ok) tmo <= '0;
      else                                             tmo <= tmo + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_sample_deframer.sv
// Bench for uart_sample_deframer: packet-level reference model checked every
// cycle, plus literal expectations for the reference packets.
module tb_uart_sample_deframer;

  localparam int T = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VLD = 1'b0;
  logic        RX_FERR = 1'b0;
  logic [15:0] SAMPLE;
  logic        SAMPLE_VLD;
  logic [4:0]  SAMPLE_IDX;
  logic        PKT_DONE;
  logic [2:0]  ERR_CODE;
  logic [15:0] PKT_CNT;
  logic [7:0]  ERR_CNT;

  uart_sample_deframer #(.SYNC_BYTE(8'hA5), .MAX_LEN(32), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .RX_FERR(RX_FERR),
    .SAMPLE(SAMPLE), .SAMPLE_VLD(SAMPLE_VLD), .SAMPLE_IDX(SAMPLE_IDX),
    .PKT_DONE(PKT_DONE), .ERR_CODE(ERR_CODE), .PKT_CNT(PKT_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // reference model state: bytes of the current packet after SYNC
  bit          in_pkt = 1'b0;
  logic [7:0]  q[$];
  int          since = 0;
  logic [15:0] e_sample = '0;
  logic [4:0]  e_idx = '0;
  bit          e_svld = 1'b0, e_done = 1'b0;
  logic [2:0]  e_err = '0;
  logic [15:0] e_pkt = '0;
  logic [7:0]  e_errc = '0;
  bit          armed = 1'b0;

  int          ncyc = 0;
  int          last_done_cyc = -1;
  int          last_byte_cyc = 0;
  logic [2:0]  last_err = '0;
  int          done_seen = 0;
  logic [15:0] got[$];
  logic [7:0]  stim[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic abort_pkt(input logic [2:0] code);
    e_done = 1'b1;
    e_err  = code;
    if (e_errc != 8'hFF) e_errc = e_errc + 8'd1;
    in_pkt = 1'b0;
  endtask

  // Expected outputs after the clock edge that samples these inputs.
  task automatic model_step(input bit r, input bit v, input bit f, input logic [7:0] d);
    int k;
    logic [7:0] x;
    e_svld = 1'b0;
    e_done = 1'b0;
    if (r) begin
      in_pkt = 1'b0; e_sample = '0; e_idx = '0; e_err = '0; e_pkt = '0; e_errc = '0;
      since = 0;
    end else if (!in_pkt) begin
      if (v && !f && d == 8'hA5) begin
        in_pkt = 1'b1;
        q.delete();
        since = 0;
      end
    end else if (f) begin
      abort_pkt(3'd3);
    end else if (v) begin
      since = 0;
      q.push_back(d);
      k = q.size();
      if (k == 1) begin
        if (d == 8'd0 || d > 8'd32) abort_pkt(3'd2);
      end else if (k == 2 * int'(q[0]) + 2) begin
        x = '0;
        for (int i = 0; i < k - 1; i++) x = x ^ q[i];
        e_done = 1'b1;
        in_pkt = 1'b0;
        if (x == d) begin
          e_err = 3'd0;
          e_pkt = e_pkt + 16'd1;
        end else begin
          e_err = 3'd1;
          if (e_errc != 8'hFF) e_errc = e_errc + 8'd1;
        end
      end else if (k % 2 == 1) begin
        e_sample = {q[k-1], q[k-2]};
        e_idx    = 5'((k - 3) / 2);
        e_svld   = 1'b1;
      end
    end else if (since == T - 1) begin
      abort_pkt(3'd4);
    end else begin
      since++;
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      chk("sample_vld", 32'(SAMPLE_VLD), 32'(e_svld));
      chk("sample",     32'(SAMPLE),     32'(e_sample));
      chk("sample_idx", 32'(SAMPLE_IDX), 32'(e_idx));
      chk("pkt_done",   32'(PKT_DONE),   32'(e_done));
      chk("err_code",   32'(ERR_CODE),   32'(e_err));
      chk("pkt_cnt",    32'(PKT_CNT),    32'(e_pkt));
      chk("err_cnt",    32'(ERR_CNT),    32'(e_errc));
      if (SAMPLE_VLD) got.push_back(SAMPLE);
      if (PKT_DONE) begin
        last_done_cyc = ncyc;
        last_err      = ERR_CODE;
        done_seen++;
      end
    end
  end

  task automatic cyc(input bit r, input bit v, input bit f, input logic [7:0] d);
    @(negedge CLK);
    #1;
    RST = r; RX_VLD = v; RX_FERR = f; RX_DATA = d;
    model_step(r, v, f, d);
    ncyc++;
    armed = 1'b1;
  endtask

  task automatic sb(input logic [7:0] b);
    cyc(1'b0, 1'b1, 1'b0, b);
    last_byte_cyc = ncyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_stim();
    foreach (stim[i]) sb(stim[i]);
  endtask

  int ds;

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    chk("rst_sample", 32'(SAMPLE), 32'h0);
    chk("rst_pkt_cnt", 32'(PKT_CNT), 32'h0);

    // good packet
    got.delete();
    stim = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h42};
    send_stim(); idle(2);
    chk("good_n", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("good_s0", 32'(got[0]), 32'h1234);
      chk("good_s1", 32'(got[1]), 32'hABCD);
    end
    chk("good_err", 32'(last_err), 32'd0);
    chk("good_pkt_cnt", 32'(PKT_CNT), 32'd1);

    // bad checksum
    stim = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h43};
    send_stim(); idle(2);
    chk("badchk_err", 32'(last_err), 32'd1);
    chk("badchk_err_cnt", 32'(ERR_CNT), 32'd1);
    chk("badchk_pkt_cnt", 32'(PKT_CNT), 32'd1);

    // length errors then a 1-sample packet
    got.delete();
    stim = '{8'hA5, 8'h00}; send_stim(); idle(2);
    chk("len0_err", 32'(last_err), 32'd2);
    stim = '{8'hA5, 8'h21}; send_stim(); idle(2);
    chk("len33_err", 32'(last_err), 32'd2);
    chk("len_no_sample", 32'(got.size()), 32'd0);
    stim = '{8'hA5, 8'h01, 8'h00, 8'h80, 8'h81}; send_stim(); idle(2);
    chk("len_next_sample", 32'(SAMPLE), 32'h8000);
    chk("len_next_err", 32'(last_err), 32'd0);

    // frame errors: alone, coincident with a byte, and ignored in IDLE
    stim = '{8'hA5, 8'h02, 8'h34}; send_stim();
    cyc(1'b0, 1'b0, 1'b1, 8'h00); idle(2);
    chk("ferr_err", 32'(last_err), 32'd3);
    stim = '{8'hA5, 8'h02, 8'h34, 8'h12}; send_stim();
    cyc(1'b0, 1'b1, 1'b1, 8'hCD); idle(2);
    chk("ferr_vld_err", 32'(last_err), 32'd3);
    ds = done_seen;
    cyc(1'b0, 1'b0, 1'b1, 8'h00); idle(2);
    chk("ferr_idle_ignored", 32'(done_seen), 32'(ds));
    stim = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01}; send_stim(); idle(2);
    chk("sync_as_data", 32'(SAMPLE), 32'hA5A5);
    chk("after_ferr_err", 32'(last_err), 32'd0);
    chk("pkt_cnt_3", 32'(PKT_CNT), 32'd3);
    chk("err_cnt_5", 32'(ERR_CNT), 32'd5);

    // timeout, then a byte in the expiry cycle
    stim = '{8'hA5, 8'h01}; send_stim();
    idle(20);
    chk("tmo_delay", 32'(last_done_cyc - last_byte_cyc), 32'd16);
    chk("tmo_err", 32'(last_err), 32'd4);
    stim = '{8'hA5, 8'h01}; send_stim();
    ds = done_seen;
    idle(15);
    stim = '{8'h00, 8'h80, 8'h81}; send_stim(); idle(2);
    chk("tmo_saved_one_done", 32'(done_seen - ds), 32'd1);
    chk("tmo_saved_err", 32'(last_err), 32'd0);
    chk("tmo_saved_pkt", 32'(PKT_CNT), 32'd4);

    // reset mid-packet
    ds = done_seen;
    stim = '{8'hA5, 8'h02, 8'h34}; send_stim();
    cyc(1'b1, 1'b0, 1'b0, 8'h00); idle(3);
    chk("rst_mid_no_done", 32'(done_seen), 32'(ds));
    chk("rst_mid_pkt", 32'(PKT_CNT), 32'd0);
    chk("rst_mid_errc", 32'(ERR_CNT), 32'd0);
    chk("rst_mid_code", 32'(ERR_CODE), 32'd0);

    // ERR_CNT saturation
    for (int i = 0; i < 256; i++) begin
      sb(8'hA5); sb(8'h00);
    end
    idle(2);
    chk("errcnt_sat", 32'(ERR_CNT), 32'hFF);
    sb(8'hA5); sb(8'h00); idle(2);
    chk("errcnt_hold", 32'(ERR_CNT), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
